// File: rtl/cw_sequencer.sv
// cw_sequencer: loads control words into a small program buffer and issues them to the Datapath
// Ports: clk, reset_b (async active-low); load/cw_in append a word; start begins execution
//   (step_mode samples free-run vs single-step); step issues one word in step mode; clear empties
//   the buffer. cw_out is the registered control word (0 = NOP), pc the index of the word on
//   cw_out, count the stored words, busy/done the run status, overflow a sticky full-load flag.
// Build option: define CW_SEQ_LOOP_EN to make RUN/STEP wrap forever, with start ending execution.
module cw_sequencer #(
  parameter int CW_WIDTH = 16,
  parameter int DEPTH    = 8,
  parameter int PC_W     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                load,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  input  logic                clear,
  output logic [CW_WIDTH-1:0] cw_out,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W:0]       count,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
`ifdef CW_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;
  state_t              r_state, w_state_nxt;
  logic [CW_WIDTH-1:0] r_mem [DEPTH];
  logic [CW_WIDTH-1:0] r_cw, w_cw_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  // r_ptr is one bit wider than pc so a single pass can count up to DEPTH and detect the end
  logic [PC_W:0]       r_ptr, w_ptr_nxt, w_ptr_inc;
  logic [PC_W:0]       r_count, w_count_nxt;
  logic                r_ovf, w_ovf_nxt, w_wr, w_last, w_stop;
  assign w_last    = (r_ptr == r_count - 1'b1);
  assign w_ptr_inc = (LOOP && w_last) ? '0 : r_ptr + 1'b1;
  assign w_stop    = LOOP && start;
  always_comb begin
    w_state_nxt = r_state;
    w_cw_nxt    = '0;
    w_pc_nxt    = r_pc;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_wr        = 1'b0;
    case (r_state)
      RUN: begin
        // the end test runs one cycle after the last issue so the last word is held a full cycle
        if (w_stop || r_ptr == r_count) w_state_nxt = DONE;
        else begin
          w_cw_nxt  = r_mem[r_ptr[PC_W-1:0]];
          w_pc_nxt  = r_ptr[PC_W-1:0];
          w_ptr_nxt = w_ptr_inc;
        end
      end
      STEP: begin
        if (w_stop) w_state_nxt = DONE;
        else if (step) begin
          w_cw_nxt  = r_mem[r_ptr[PC_W-1:0]];
          w_pc_nxt  = r_ptr[PC_W-1:0];
          w_ptr_nxt = w_ptr_inc;
          if (!LOOP && w_last) w_state_nxt = DONE;
        end
      end
      default: begin
        if (start && r_count != '0) begin
          w_ptr_nxt   = '0;
          w_pc_nxt    = '0;
          w_state_nxt = step_mode ? STEP : RUN;
        end else if (clear) begin
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end else if (load) begin
          w_state_nxt = IDLE;
          if (r_count == (PC_W+1)'(DEPTH)) w_ovf_nxt = 1'b1;
          else begin
            w_wr        = 1'b1;
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
      r_cw    <= '0;
      r_pc    <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cw    <= w_cw_nxt;
      r_pc    <= w_pc_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[PC_W-1:0]] <= cw_in;
  end
  assign cw_out   = r_cw;
  assign pc       = r_pc;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign busy     = (r_state == RUN) || (r_state == STEP);
  assign done     = (r_state == DONE);
endmodule

// File: tb/tb_cw_sequencer.sv
// tb_cw_sequencer: scoreboard bench for cw_sequencer (per-cycle expected cw_out/busy/done queue)
module tb_cw_sequencer;
  logic        clk = 1'b0, reset_b = 1'b0, load = 1'b0, start = 1'b0;
  logic        step_mode = 1'b0, step = 1'b0, clear = 1'b0;
  logic [15:0] cw_in = '0, cw_out;
  logic [2:0]  pc;
  logic [3:0]  count;
  logic        busy, done, overflow;
  int          n_tot = 0, n_bad = 0;
  typedef struct packed {logic [15:0] cw; logic busy; logic done;} exp_t;
  exp_t        sb[$];
  logic [15:0] w3 [3] = '{16'hA001, 16'h2403, 16'h0000};
  always #5 clk = ~clk;
  cw_sequencer dut (
    .clk(clk), .reset_b(reset_b), .load(load), .cw_in(cw_in), .start(start),
    .step_mode(step_mode), .step(step), .clear(clear), .cw_out(cw_out), .pc(pc),
    .count(count), .busy(busy), .done(done), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] cw, input logic b, input logic d);
    sb.push_back({cw, b, d});
  endtask
  task automatic tick_chk(input string tag);
    exp_t e;
    tick;
    e = sb.pop_front();
    chk({tag, "_cw"}, 32'(cw_out), 32'(e.cw));
    chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
    chk({tag, "_done"}, 32'(done), 32'(e.done));
  endtask
  task automatic do_load(input logic [15:0] w);
    cw_in = w;
    load  = 1'b1;
    tick;
    load  = 1'b0;
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_cw", 32'(cw_out), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset_b = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) do_load(w3[i]);
    chk("load_count", 32'(count), 3);
    chk("load_cw", 32'(cw_out), 0);
    chk("load_busy", 32'(busy), 0);
    chk("load_ovf", 32'(overflow), 0);
`ifndef CW_SEQ_LOOP_EN
    start = 1'b1;
    push(16'h0, 1, 0);
    tick_chk("run_entry");
    start = 1'b0;
    for (int i = 0; i < 3; i++) push(w3[i], 1, 0);
    push(16'h0, 0, 1);
    repeat (4) tick_chk("run");
    chk("run_pc", 32'(pc), 2);
    step_mode = 1'b1;
    start = 1'b1;
    push(16'h0, 1, 0);
    tick_chk("step_entry");
    start = 1'b0;
    step_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 9; j++) begin
        if (j == 3) begin cw_in = 16'hFFFF; load = 1'b1; end
        if (j == 6) clear = 1'b1;
        push(16'h0, 1, 0);
        tick_chk("step_wait");
        load = 1'b0;
        clear = 1'b0;
      end
      step = 1'b1;
      push(w3[k], k != 2, k == 2);
      tick_chk("step_issue");
      step = 1'b0;
    end
    push(16'h0, 0, 1);
    tick_chk("step_end");
    chk("step_count", 32'(count), 3);
    chk("step_pc", 32'(pc), 2);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_count", 32'(count), 0);
    chk("clr_done", 32'(done), 0);
    for (int i = 0; i < 10; i++) do_load(16'h1000 + 16'(i));
    chk("full_count", 32'(count), 8);
    chk("full_ovf", 32'(overflow), 1);
    start = 1'b1;
    push(16'h0, 1, 0);
    tick_chk("full_entry");
    start = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), 1, 0);
    push(16'h0, 0, 1);
    repeat (9) tick_chk("full_run");
    chk("full_pc", 32'(pc), 7);
    chk("full_ovf_sticky", 32'(overflow), 1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("ovf_clr_count", 32'(count), 0);
    chk("ovf_clr_ovf", 32'(overflow), 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("empty_start_busy", 32'(busy), 0);
    chk("empty_start_done", 32'(done), 0);
    do_load(16'hBEEF);
    start = 1'b1;
    load = 1'b1;
    cw_in = 16'hCAFE;
    push(16'h0, 1, 0);
    tick_chk("sl_entry");
    start = 1'b0;
    load = 1'b0;
    chk("sl_count", 32'(count), 1);
    push(16'hBEEF, 1, 0);
    push(16'h0, 0, 1);
    repeat (2) tick_chk("sl_run");
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_rst_cw", 32'(cw_out), 32'hBEEF);
    #2 reset_b = 1'b0;
    #1;
    chk("arst_cw", 32'(cw_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(count), 0);
    @(negedge clk);
    reset_b = 1'b1;
`else
    clear = 1'b1;
    tick;
    clear = 1'b0;
    do_load(16'h1111);
    do_load(16'h2222);
    chk("loop_count", 32'(count), 2);
    start = 1'b1;
    push(16'h0, 1, 0);
    tick_chk("loop_entry");
    start = 1'b0;
    for (int i = 0; i < 7; i++) push((i % 2) ? 16'h2222 : 16'h1111, 1, 0);
    repeat (7) tick_chk("loop_run");
    start = 1'b1;
    push(16'h0, 0, 1);
    tick_chk("loop_stop");
    start = 1'b0;
    push(16'h0, 0, 1);
    tick_chk("loop_done");
`endif
    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
